// File: rtl/line_assembler.sv
// Streaming single-line RV32I assembler: folds, tokenises and encodes one ASCII
// line per new_line pulse. Define HEX_IMM_EN to accept "0x" hexadecimal immediates.
module line_assembler #(
   parameter int CHAR_PER_LINE = 64,
   parameter int MNEM_CHARS    = 4
) (
   input  logic        clk_in,
   input  logic        rst_in,
   input  logic        new_line,
   input  logic        new_character,
   input  logic [7:0]  incoming_character,
   output logic [31:0] instruction,
   output logic        done_flag,
   output logic        error_flag,
   output logic        busy_flag,
   output logic [2:0]  error_code
);
   localparam int MW = 8 * MNEM_CHARS;
   localparam int LW = $clog2(MNEM_CHARS + 1);
   localparam int CW = $clog2(CHAR_PER_LINE + 1);
   localparam logic [20:0] ACC_MAX = 21'h0F_FFFF;

   localparam logic [2:0] E_MNEM    = 3'd1;
   localparam logic [2:0] E_REG     = 3'd2;
   localparam logic [2:0] E_RANGE   = 3'd3;
   localparam logic [2:0] E_SYNTAX  = 3'd4;
   localparam logic [2:0] E_EARLY   = 3'd5;
   localparam logic [2:0] E_LENGTH  = 3'd6;
   localparam logic [2:0] E_NEWLINE = 3'd7;

   typedef enum logic [2:0] {S_IDLE, S_MNEMONIC, S_OPERAND, S_DONE, S_ERROR} state_t;
   typedef enum logic [1:0] {PH_WAIT, PH_IN, PH_AFTER} phase_t;
   typedef enum logic [1:0] {K_NONE, K_R, K_I, K_U} kind_t;
   typedef enum logic [3:0] {
      A_NONE, A_ERR, A_BLANK, A_DONE, A_SHIFT, A_TO_OPER,
      A_FEED, A_FIN_AFTER, A_FIN_NEXT, A_NEXT
   } act_t;

   // Operand token being scanned: shared by register and immediate operands.
   typedef struct packed {
      logic        x;
      logic        hex;
      logic        neg;
      logic [1:0]  digits;
      logic [20:0] acc;
      logic        ovf;
   } tok_t;

   state_t         state;
   phase_t         phase;
   logic [MW-1:0]  mnem;
   logic [LW-1:0]  mnem_len;
   logic [CW-1:0]  char_count;
   logic [1:0]     op_idx;
   logic [4:0]     rd, rs1, rs2;
   logic           imm_neg;
   logic [20:0]    imm_mag;
   tok_t           tok;

   logic [7:0]     ch;
   logic           is_ws, is_comma, is_nl, is_letter, is_dec;
   logic [3:0]     dec_val;
   logic [CW:0]    count_next;
   logic           len_over, take;
   kind_t          kind;
   logic [2:0]     funct3;
   logic           is_sub, last_op, cur_is_reg;
   logic [2:0]     fin_err, feed_err, act_err;
   tok_t           tok_n;
   logic           dig_ok;
   logic [3:0]     dval;
   logic [25:0]    prod;
   act_t           act;
   logic [4:0]     eff_rd, eff_rs1, eff_rs2;
   logic           eff_neg;
   logic [20:0]    eff_mag;
   logic [19:0]    imm_tc;
   logic [31:0]    instr_enc;

   always_comb begin
      // NOTE: every always_comb output gets a default first so no latch can be inferred.
      ch = incoming_character;
      if (ch >= 8'h41 && ch <= 8'h5A) ch = ch | 8'h20;
      is_ws      = (ch == 8'h20) || (ch == 8'h09);
      is_comma   = (ch == 8'h2C);
      is_nl      = (ch == 8'h0A);
      is_letter  = (ch >= 8'h61) && (ch <= 8'h7A);
      is_dec     = (ch >= 8'h30) && (ch <= 8'h39);
      dec_val    = 4'(ch - 8'h30);
      count_next = {1'b0, char_count} + (CW + 1)'(1);
      len_over   = count_next > (CW + 1)'(CHAR_PER_LINE);
      take       = new_character && !new_line && (state == S_MNEMONIC || state == S_OPERAND);
   end

   always_comb begin
      kind   = K_NONE;
      funct3 = 3'b000;
      is_sub = 1'b0;
      case (mnem)
         MW'(32'h0061_6464): kind = K_R;
         MW'(32'h0073_7562): begin kind = K_R; is_sub = 1'b1; end
         MW'(32'h0061_6E64): begin kind = K_R; funct3 = 3'b111; end
         MW'(32'h0000_6F72): begin kind = K_R; funct3 = 3'b110; end
         MW'(32'h0078_6F72): begin kind = K_R; funct3 = 3'b100; end
         MW'(32'h6164_6469): kind = K_I;
         MW'(32'h616E_6469): begin kind = K_I; funct3 = 3'b111; end
         MW'(32'h006F_7269): begin kind = K_I; funct3 = 3'b110; end
         MW'(32'h786F_7269): begin kind = K_I; funct3 = 3'b100; end
         MW'(32'h006C_7569): kind = K_U;
         default: ;
      endcase
      last_op    = (kind == K_U) ? (op_idx == 2'd1) : (op_idx == 2'd2);
      cur_is_reg = (kind == K_R) || (kind == K_I && op_idx != 2'd2) ||
                   (kind == K_U && op_idx == 2'd0);
   end

   // Validation of the current token when a separator closes it.
   always_comb begin
      fin_err = 3'd0;
      if (tok.digits == 2'd0)
         fin_err = E_SYNTAX;
      else if (cur_is_reg) begin
         if (tok.acc > 21'd31) fin_err = E_REG;
      end else if (tok.ovf)
         fin_err = E_RANGE;
      else if (kind == K_U) begin
         if (tok.neg && tok.acc != 21'd0) fin_err = E_RANGE;
      end else if (tok.acc > (tok.neg ? 21'd2048 : 21'd2047))
         fin_err = E_RANGE;
   end

   always_comb begin
      tok_n    = tok;
      feed_err = 3'd0;
      dig_ok   = is_dec;
      dval     = dec_val;
`ifdef HEX_IMM_EN
      if (tok.hex && ch >= 8'h61 && ch <= 8'h66) begin
         dig_ok = 1'b1;
         dval   = 4'(ch - 8'h57);
      end
`endif
      prod = tok.hex ? (26'(tok.acc) << 4) + 26'(dval)
                     : 26'(tok.acc) * 26'd10 + 26'(dval);
      if (cur_is_reg) begin
         if (!tok.x) begin
            if (ch == 8'h78) tok_n.x = 1'b1;
            else             feed_err = E_REG;
         end else if (is_dec && tok.digits < 2'd2) begin
            tok_n.acc    = prod[20:0];
            tok_n.digits = tok.digits + 2'd1;
         end else
            feed_err = E_REG;
      end else if (ch == 8'h2D && phase == PH_WAIT)
         tok_n.neg = 1'b1;
`ifdef HEX_IMM_EN
      else if (ch == 8'h78 && !tok.hex && tok.digits == 2'd1 && tok.acc == 21'd0) begin
         tok_n.hex    = 1'b1;
         tok_n.digits = 2'd0;
      end
`endif
      else if (dig_ok) begin
         // Saturate rather than wrap so a huge literal is still reported as out of range.
         if (tok.ovf || prod > 26'(ACC_MAX)) begin
            tok_n.acc = ACC_MAX;
            tok_n.ovf = 1'b1;
         end else
            tok_n.acc = prod[20:0];
         tok_n.digits = (tok.digits == 2'd3) ? 2'd3 : tok.digits + 2'd1;
      end else
         feed_err = E_SYNTAX;
   end

   always_comb begin
      act     = A_NONE;
      act_err = 3'd0;
      if (len_over) begin
         act = A_ERR; act_err = E_LENGTH;
      end else if (state == S_MNEMONIC) begin
         if (is_ws) begin
            if (mnem_len != '0) begin
               if (kind != K_NONE) act = A_TO_OPER;
               else begin act = A_ERR; act_err = E_MNEM; end
            end
         end else if (is_nl && mnem_len == '0)
            act = A_BLANK;
         else if (is_nl || is_comma) begin
            act     = A_ERR;
            act_err = (mnem_len == '0) ? E_SYNTAX : (kind != K_NONE) ? E_EARLY : E_MNEM;
         end else if (!is_letter) begin
            act = A_ERR; act_err = E_SYNTAX;
         end else if (mnem_len == LW'(MNEM_CHARS)) begin
            act = A_ERR; act_err = E_MNEM;
         end else
            act = A_SHIFT;
      end else if (is_ws) begin
         if (phase == PH_IN) begin
            act = (fin_err != 3'd0) ? A_ERR : A_FIN_AFTER; act_err = fin_err;
         end
      end else if (is_comma || is_nl) begin
         if (phase == PH_WAIT) begin
            act = A_ERR; act_err = is_comma ? E_SYNTAX : E_EARLY;
         end else if (phase == PH_IN && fin_err != 3'd0) begin
            act = A_ERR; act_err = fin_err;
         end else if (is_nl) begin
            if (last_op) act = A_DONE;
            else begin act = A_ERR; act_err = E_EARLY; end
         end else if (last_op) begin
            act = A_ERR; act_err = E_SYNTAX;
         end else
            act = (phase == PH_IN) ? A_FIN_NEXT : A_NEXT;
      end else if (phase == PH_AFTER) begin
         act = A_ERR; act_err = E_SYNTAX;
      end else if (feed_err != 3'd0) begin
         act = A_ERR; act_err = feed_err;
      end else
         act = A_FEED;
   end

   // The final operand may still be in the token register when '\n' arrives.
   always_comb begin
      eff_rd  = rd;
      eff_rs1 = rs1;
      eff_rs2 = rs2;
      eff_neg = imm_neg;
      eff_mag = imm_mag;
      if (phase == PH_IN) begin
         if (!cur_is_reg) begin
            eff_neg = tok.neg;
            eff_mag = tok.acc;
         end else if (op_idx == 2'd0) eff_rd  = tok.acc[4:0];
         else if (op_idx == 2'd1)     eff_rs1 = tok.acc[4:0];
         else                         eff_rs2 = tok.acc[4:0];
      end
      imm_tc = eff_neg ? 20'(21'd0 - eff_mag) : eff_mag[19:0];
      case (kind)
         K_R:     instr_enc = {1'b0, is_sub, 5'b0, eff_rs2, eff_rs1, funct3, eff_rd, 7'h33};
         K_I:     instr_enc = {imm_tc[11:0], eff_rs1, funct3, eff_rd, 7'h13};
         K_U:     instr_enc = {imm_tc, eff_rd, 7'h37};
         default: instr_enc = 32'h0;
      endcase
   end

   // NOTE: state updates use non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         state       <= S_IDLE;
         phase       <= PH_WAIT;
         mnem        <= '0;
         mnem_len    <= '0;
         char_count  <= '0;
         op_idx      <= 2'd0;
         rd          <= 5'd0;
         rs1         <= 5'd0;
         rs2         <= 5'd0;
         imm_neg     <= 1'b0;
         imm_mag     <= 21'd0;
         tok         <= '0;
         instruction <= 32'h0;
         done_flag   <= 1'b0;
         error_flag  <= 1'b0;
         busy_flag   <= 1'b0;
         error_code  <= 3'd0;
      end else if (new_line) begin
         if (state == S_MNEMONIC || state == S_OPERAND) begin
            state      <= S_ERROR;
            error_flag <= 1'b1;
            error_code <= E_NEWLINE;
            busy_flag  <= 1'b0;
         end else begin
            state       <= S_MNEMONIC;
            phase       <= PH_WAIT;
            mnem        <= '0;
            mnem_len    <= '0;
            char_count  <= '0;
            op_idx      <= 2'd0;
            rd          <= 5'd0;
            rs1         <= 5'd0;
            rs2         <= 5'd0;
            imm_neg     <= 1'b0;
            imm_mag     <= 21'd0;
            tok         <= '0;
            instruction <= 32'h0;
            done_flag   <= 1'b0;
            error_flag  <= 1'b0;
            busy_flag   <= 1'b1;
            error_code  <= 3'd0;
         end
      end else if (take) begin
         if (!len_over) char_count <= count_next[CW-1:0];
         case (act)
            A_ERR: begin
               state      <= S_ERROR;
               error_flag <= 1'b1;
               error_code <= act_err;
               busy_flag  <= 1'b0;
            end
            A_BLANK: begin
               state     <= S_IDLE;
               busy_flag <= 1'b0;
            end
            A_DONE: begin
               state       <= S_DONE;
               done_flag   <= 1'b1;
               busy_flag   <= 1'b0;
               instruction <= instr_enc;
            end
            A_SHIFT: begin
               mnem     <= {mnem[MW-9:0], ch};
               mnem_len <= mnem_len + LW'(1);
            end
            A_TO_OPER: begin
               state  <= S_OPERAND;
               phase  <= PH_WAIT;
               op_idx <= 2'd0;
            end
            A_FEED: begin
               phase <= PH_IN;
               tok   <= tok_n;
            end
            A_FIN_AFTER, A_FIN_NEXT, A_NEXT: begin
               if (act != A_NEXT) begin
                  if (!cur_is_reg) begin
                     imm_neg <= tok.neg;
                     imm_mag <= tok.acc;
                  end else if (op_idx == 2'd0) rd  <= tok.acc[4:0];
                  else if (op_idx == 2'd1)     rs1 <= tok.acc[4:0];
                  else                         rs2 <= tok.acc[4:0];
               end
               if (act == A_FIN_AFTER)
                  phase <= PH_AFTER;
               else begin
                  phase  <= PH_WAIT;
                  op_idx <= op_idx + 2'd1;
                  tok    <= '0;
               end
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_line_assembler.sv
// Directed-vector bench for line_assembler: a table of source lines with
// hand-encoded results plus sequences for reset, new_line abuse and line length.
module tb_line_assembler;
   logic        clk_in = 1'b0;
   logic        rst_in = 1'b0;
   logic        new_line = 1'b0;
   logic        new_character = 1'b0;
   logic [7:0]  incoming_character = 8'h00;
   logic [31:0] instruction;
   logic        done_flag, error_flag, busy_flag;
   logic [2:0]  error_code;

   int total = 0;
   int bad   = 0;

   line_assembler #(.CHAR_PER_LINE(64), .MNEM_CHARS(4)) dut (
      .clk_in(clk_in), .rst_in(rst_in), .new_line(new_line),
      .new_character(new_character), .incoming_character(incoming_character),
      .instruction(instruction), .done_flag(done_flag), .error_flag(error_flag),
      .busy_flag(busy_flag), .error_code(error_code)
   );

   always #5 clk_in = ~clk_in;

   typedef struct {
      string       line;
      logic        exp_done;
      logic        exp_err;
      logic [2:0]  exp_code;
      logic [31:0] exp_instr;
   } vec_t;

   vec_t vecs[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic pulse_new_line();
      @(negedge clk_in);
      new_line      = 1'b1;
      new_character = 1'b0;
      @(negedge clk_in);
      new_line = 1'b0;
   endtask

   // Inputs change and outputs are sampled on the falling edge.
   task automatic feed(input string s);
      for (int i = 0; i < s.len(); i++) begin
         new_character      = 1'b1;
         incoming_character = s[i];
         @(negedge clk_in);
      end
      new_character = 1'b0;
   endtask

   task automatic check_result(input string tag, input logic d, input logic e,
                               input logic [2:0] c, input logic [31:0] ins);
      check({tag, " done"},  32'(done_flag),  32'(d));
      check({tag, " error"}, 32'(error_flag), 32'(e));
      check({tag, " code"},  32'(error_code), 32'(c));
      check({tag, " instr"}, instruction, ins);
      check({tag, " busy"},  32'(busy_flag), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      string pad;
      vecs.push_back('{"add x1, x2, x3\n",            1'b1, 1'b0, 3'd0, 32'h003100B3});
      vecs.push_back('{"ADDI x5,x6,-1\n",             1'b1, 1'b0, 3'd0, 32'hFFF30293});
      vecs.push_back('{"lui x10, 74565\n",            1'b1, 1'b0, 3'd0, 32'h12345537});
      vecs.push_back('{"  xor\tx31,x0,x17 \n",        1'b1, 1'b0, 3'd0, 32'h01104FB3});
      vecs.push_back('{"sub x3,x4,x5\n",              1'b1, 1'b0, 3'd0, 32'h405201B3});
      vecs.push_back('{"addi x1, x2, -2048\n",        1'b1, 1'b0, 3'd0, 32'h80010093});
      vecs.push_back('{"andi x1,x2,2047\n",           1'b1, 1'b0, 3'd0, 32'h7FF17093});
      vecs.push_back('{"lui x1, 1048575\n",           1'b1, 1'b0, 3'd0, 32'hFFFFF0B7});
      vecs.push_back('{"sub x1, x2, x32\n",           1'b0, 1'b1, 3'd2, 32'h0});
      vecs.push_back('{"addi x1, x2, 2048\n",         1'b0, 1'b1, 3'd3, 32'h0});
      vecs.push_back('{"mul x1,x2,x3\n",              1'b0, 1'b1, 3'd1, 32'h0});
      vecs.push_back('{"addiu x1\n",                  1'b0, 1'b1, 3'd1, 32'h0});
      vecs.push_back('{"or x1,y2,x3\n",               1'b0, 1'b1, 3'd2, 32'h0});
      vecs.push_back('{"lui x1, 1048576\n",           1'b0, 1'b1, 3'd3, 32'h0});
      vecs.push_back('{"addi x1,x2,99999999999\n",    1'b0, 1'b1, 3'd3, 32'h0});
      vecs.push_back('{"add x1,x2\n",                 1'b0, 1'b1, 3'd5, 32'h0});
      vecs.push_back('{"add, x1\n",                   1'b0, 1'b1, 3'd5, 32'h0});
      vecs.push_back('{"addi x1,x2,\n",               1'b0, 1'b1, 3'd5, 32'h0});
      vecs.push_back('{"addi x1,x2,-\n",              1'b0, 1'b1, 3'd4, 32'h0});
      vecs.push_back('{"add x1,x2,x3,\n",             1'b0, 1'b1, 3'd4, 32'h0});
      vecs.push_back('{"add x1,x2,x3 y\n",            1'b0, 1'b1, 3'd4, 32'h0});
      vecs.push_back('{"\n",                          1'b0, 1'b0, 3'd0, 32'h0});
      vecs.push_back('{"   \n",                       1'b0, 1'b0, 3'd0, 32'h0});
`ifdef HEX_IMM_EN
      vecs.push_back('{"ori x1,x0,0x7ff\n",           1'b1, 1'b0, 3'd0, 32'h7FF06093});
`else
      vecs.push_back('{"ori x1,x0,0x7ff\n",           1'b0, 1'b1, 3'd4, 32'h0});
`endif

      // Reset state.
      #12;
      check("reset instr", instruction, 32'h0);
      check("reset flags", 32'({done_flag, error_flag, busy_flag}), 32'd0);
      check("reset code",  32'(error_code), 32'd0);
      @(negedge clk_in);
      rst_in = 1'b1;

      foreach (vecs[i]) begin
         pulse_new_line();
         check($sformatf("v%0d busy", i), 32'(busy_flag), 32'd1);
         feed(vecs[i].line);
         check_result($sformatf("v%0d", i), vecs[i].exp_done, vecs[i].exp_err,
                      vecs[i].exp_code, vecs[i].exp_instr);
      end

      // Results hold while further characters arrive without new_line.
      pulse_new_line();
      feed("sub x3,x4,x5\n");
      feed("add x9");
      check("hold done",  32'(done_flag), 32'd1);
      check("hold instr", instruction, 32'h405201B3);

      // error_flag rises the cycle after the offending character.
      pulse_new_line();
      feed("mul");
      check("mnem busy before sep", 32'(busy_flag), 32'd1);
      feed(" ");
      check("mnem err timing", 32'(error_flag), 32'd1);
      check("mnem err code",   32'(error_code), 32'd1);
      check("mnem err busy",   32'(busy_flag),  32'd0);

      // new_line in the middle of a line.
      pulse_new_line();
      feed("add x1,");
      pulse_new_line();
      check_result("nl mid", 1'b0, 1'b1, 3'd7, 32'h0);

      // new_line wins over a simultaneous character: the 'a' is dropped.
      @(negedge clk_in);
      new_line           = 1'b1;
      new_character      = 1'b1;
      incoming_character = 8'h61;
      @(negedge clk_in);
      new_line      = 1'b0;
      new_character = 1'b0;
      feed("dd x1,x2,x3\n");
      check_result("nl+char", 1'b0, 1'b1, 3'd1, 32'h0);

      // Line length: 64 characters accepted, 65 rejected.
      pad = "add x1, x2, x3";
      while (pad.len() < 63) pad = {pad, " "};
      pulse_new_line();
      feed({pad, "\n"});
      check_result("len64", 1'b1, 1'b0, 3'd0, 32'h003100B3);
      pulse_new_line();
      feed({pad, " \n"});
      check_result("len65", 1'b0, 1'b1, 3'd6, 32'h0);

      // Asynchronous reset in the middle of a line.
      pulse_new_line();
      feed("add x1, x2");
      #2 rst_in = 1'b0;
      #1;
      check("midreset instr", instruction, 32'h0);
      check("midreset flags", 32'({done_flag, error_flag, busy_flag}), 32'd0);
      check("midreset code",  32'(error_code), 32'd0);
      @(negedge clk_in);
      rst_in = 1'b1;
      feed(", x3\n");
      check_result("idle after reset", 1'b0, 1'b0, 3'd0, 32'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
